// File: rtl/bms_fault_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bms_fault_detector: OV/UV/OC/OT threshold, hysteresis and debounce front-end.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module bms_fault_detector #(
  parameter int VW      = 16,
  parameter int IW      = 16,
  parameter int TW      = 8,
  parameter int CW      = 4,
  parameter int OV_SET  = 4200,
  parameter int OV_CLR  = 4100,
  parameter int UV_SET  = 2800,
  parameter int UV_CLR  = 2900,
  parameter int OC_SET  = 20000,
  parameter int OC_CLR  = 18000,
  parameter int OT_SET  = 60,
  parameter int OT_CLR  = 55,
  parameter int DEB_SET = 4,
  parameter int DEB_CLR = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [VW-1:0]        cell_mv,
  input  logic signed [IW-1:0] pack_ma,
  input  logic signed [TW-1:0] temp_c,
  input  logic                 clear_faults,
  output logic                 ov_fault,
  output logic                 uv_fault,
  output logic                 oc_fault,
  output logic                 ot_fault,
  output logic                 any_fault,
  output logic                 sample_done
);

  typedef enum logic {ST_OK = 1'b0, ST_FAULT = 1'b1} state_e;

  localparam logic [VW-1:0]        c_ov_set  = VW'(OV_SET);
  localparam logic [VW-1:0]        c_ov_clr  = VW'(OV_CLR);
  localparam logic [VW-1:0]        c_uv_set  = VW'(UV_SET);
  localparam logic [VW-1:0]        c_uv_clr  = VW'(UV_CLR);
  localparam logic [IW:0]          c_oc_set  = (IW+1)'(OC_SET);
  localparam logic [IW:0]          c_oc_clr  = (IW+1)'(OC_CLR);
  localparam logic signed [TW-1:0] c_ot_set  = TW'(OT_SET);
  localparam logic signed [TW-1:0] c_ot_clr  = TW'(OT_CLR);
  localparam logic [CW-1:0]        c_deb_set = CW'(DEB_SET);
  localparam logic [CW-1:0]        c_deb_clr = CW'(DEB_CLR);
  localparam logic [CW-1:0]        c_cnt_max = '1;

  // Sign-extend by one bit so the most negative current has a representable magnitude.
  logic [IW:0] cur_ext_w;
  logic [IW:0] cur_mag_w;
  assign cur_ext_w = {pack_ma[IW-1], pack_ma};
  assign cur_mag_w = cur_ext_w[IW] ? (~cur_ext_w + 1'b1) : cur_ext_w;

  // Channel order: 0=OV, 1=UV, 2=OC, 3=OT
  logic [3:0] viol_w;
  logic [3:0] clr_ok_w;
  assign viol_w[0]   = (cell_mv >= c_ov_set);
  assign clr_ok_w[0] = (cell_mv <= c_ov_clr);
  assign viol_w[1]   = (cell_mv <= c_uv_set);
  assign clr_ok_w[1] = (cell_mv >= c_uv_clr);
  assign viol_w[2]   = (cur_mag_w >= c_oc_set);
  assign clr_ok_w[2] = (cur_mag_w <= c_oc_clr);
  assign viol_w[3]   = (temp_c >= c_ot_set);
  assign clr_ok_w[3] = (temp_c <= c_ot_clr);

  logic [3:0] fault_d;
  logic [3:0] fault_q;
  logic       any_q;
  logic       done_q;

  for (genvar g = 0; g < 4; g++) begin : g_chan
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear_faults) begin
        state_d = ST_OK;
        cnt_d   = '0;
      end else if (sample_valid) begin
        case (state_q)
          ST_OK: begin
            if (!viol_w[g]) begin
              cnt_d = '0;
            end else if (cnt_inc == c_deb_set) begin
              state_d = ST_FAULT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            if (!clr_ok_w[g]) begin
              cnt_d = '0;
            end else if (cnt_inc == c_deb_clr) begin
              state_d = ST_OK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_OK;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign fault_d[g] = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
      any_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fault_q <= fault_d;
      any_q   <= |fault_d;
      done_q  <= sample_valid;
    end
  end

  assign ov_fault    = fault_q[0];
  assign uv_fault    = fault_q[1];
  assign oc_fault    = fault_q[2];
  assign ot_fault    = fault_q[3];
  assign any_fault   = any_q;
  assign sample_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bms_fault_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bms_fault_detector: directed vectors with a queued scoreboard on sample_done.
// ---------------------------------------------------------------------------
module tb_bms_fault_detector;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_valid;
  logic [15:0]       cell_mv;
  logic signed [15:0] pack_ma;
  logic signed [7:0] temp_c;
  logic              clear_faults;
  logic              ov_fault, uv_fault, oc_fault, ot_fault, any_fault, sample_done;

  int checks = 0;
  int passed = 0;
  logic [4:0] exp_q[$];

  bms_fault_detector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .cell_mv      (cell_mv),
    .pack_ma      (pack_ma),
    .temp_c       (temp_c),
    .clear_faults (clear_faults),
    .ov_fault     (ov_fault),
    .uv_fault     (uv_fault),
    .oc_fault     (oc_fault),
    .ot_fault     (ot_fault),
    .any_fault    (any_fault),
    .sample_done  (sample_done)
  );

  always #5 clk = ~clk;

  // {ov, uv, oc, ot, any}
  function automatic logic [4:0] e(input logic ov, input logic uv, input logic oc, input logic ot);
    return {ov, uv, oc, ot, ov | uv | oc | ot};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (ov,uv,oc,ot,any)", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && sample_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_sample_done: got sample_done=1 expected no pending sample");
      end else begin
        check("sample_flags", {ov_fault, uv_fault, oc_fault, ot_fault, any_fault}, exp_q.pop_front());
      end
    end
  end

  task automatic strobe(input int mv, input int ma, input int t, input logic [4:0] exp,
                        input logic clr = 1'b0);
    sample_valid = 1'b1;
    clear_faults = clr;
    cell_mv      = 16'(mv);
    pack_ma      = 16'(ma);
    temp_c       = 8'(t);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    clear_faults = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; clear_faults = 1'b0;
    cell_mv = 16'd3700; pack_ma = '0; temp_c = 8'sd25;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {ov_fault, uv_fault, oc_fault, ot_fault, any_fault}, 5'b0);
    check("reset_done", {4'b0, sample_done}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // OV debounce: an in-range sample restarts the count
    repeat (3) strobe(4250, 0, 25, e(0,0,0,0));
    strobe(4150, 0, 25, e(0,0,0,0));
    repeat (3) strobe(4250, 0, 25, e(0,0,0,0));
    strobe(4250, 0, 25, e(1,0,0,0));
    // OV release: band samples restart the clear count; 4100 is inclusive
    repeat (4) strobe(4050, 0, 25, e(1,0,0,0));
    strobe(4150, 0, 25, e(1,0,0,0));
    repeat (3) strobe(4050, 0, 25, e(1,0,0,0));
    strobe(4150, 0, 25, e(1,0,0,0));
    repeat (7) strobe(4050, 0, 25, e(1,0,0,0));
    strobe(4100, 0, 25, e(0,0,0,0));

    // OC: most negative current, then release at zero
    repeat (3) strobe(3700, -32768, 25, e(0,0,0,0));
    strobe(3700, -32768, 25, e(0,0,1,0));
    repeat (7) strobe(3700, 0, 25, e(0,0,1,0));
    strobe(3700, 0, 25, e(0,0,0,0));
    // OC boundaries: 20000 violates, 19999 does not; 18000 clears, 18001 is in band
    repeat (3) strobe(3700, -20000, 25, e(0,0,0,0));
    strobe(3700, 19999, 25, e(0,0,0,0));
    repeat (3) strobe(3700, 20000, 25, e(0,0,0,0));
    strobe(3700, 20000, 25, e(0,0,1,0));
    repeat (7) strobe(3700, 18000, 25, e(0,0,1,0));
    strobe(3700, 18001, 25, e(0,0,1,0));
    repeat (7) strobe(3700, -18000, 25, e(0,0,1,0));
    strobe(3700, -18000, 25, e(0,0,0,0));

    // OT: negative temperature never sets, and always clears
    repeat (5) strobe(3700, 0, -40, e(0,0,0,0));
    repeat (3) strobe(3700, 0, 60, e(0,0,0,0));
    strobe(3700, 0, 60, e(0,0,0,1));
    strobe(3700, 0, 59, e(0,0,0,1));
    repeat (7) strobe(3700, 0, -40, e(0,0,0,1));
    strobe(3700, 0, -40, e(0,0,0,0));

    // UV with idle gaps, then clear coinciding with a strobe
    strobe(2700, 0, 25, e(0,0,0,0));
    strobe(2700, 0, 25, e(0,0,0,0));
    idle(3);
    strobe(2700, 0, 25, e(0,0,0,0));
    idle(5);
    strobe(2700, 0, 25, e(0,1,0,0));
    strobe(2700, 0, 25, e(0,0,0,0), 1'b1);
    repeat (3) strobe(2800, 0, 25, e(0,0,0,0));
    strobe(2800, 0, 25, e(0,1,0,0));
    clear_faults = 1'b1;
    @(posedge clk); #1;
    clear_faults = 1'b0;
    @(negedge clk);
    check("clear_no_sample", {ov_fault, uv_fault, oc_fault, ot_fault, any_fault}, 5'b0);
    check("clear_no_done", {4'b0, sample_done}, 5'b0);
    @(posedge clk); #1;

    // Reset mid-debounce discards the partial OV count
    repeat (3) strobe(4250, 0, 25, e(0,0,0,0));
    drain();
    rst_n = 1'b0;
    idle(2);
    check("midreset_flags", {ov_fault, uv_fault, oc_fault, ot_fault, any_fault}, 5'b0);
    rst_n = 1'b1;
    idle(1);
    repeat (3) strobe(4250, 0, 25, e(0,0,0,0));
    strobe(4250, 0, 25, e(1,0,0,0));
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
